rr_pipe_arbiter: RTL and testbench
==================================

Name: rr_pipe_arbiter

Overview:
- Round-robin arbiter that shares one registered valid/ready downstream channel between N upstream requesters.
- Each requester presents a DW-bit beat with valid/ready handshaking.
- The winning beat is captured into a single output register, a depth-1 pipe stage, and presented downstream with the winner's index.
- Sits in front of a shared pipe stage or consumer, so several producers feed one pipeline at full throughput.

Parameters:
N, 4, number of requesters (2..8)
DW, 3, data width per beat
IW, 2, width of grant index; must equal ceil(log2(N))

Ports:
sys_clk  input  1  single clock; all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
valid_up  input  N  per-requester valid; bit i belongs to requester i
data_up  input  N*DW  requester i data at bits [i*DW +: DW]
ready_up  output  N  per-requester ready; at most one bit high per cycle
valid_down  output  1  output register holds a beat
data_down  output  DW  registered beat
grant_id  output  IW  index of the requester that supplied data_down
ready_down  input  1  downstream accepts the beat when high with valid_down

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is synchronous and active-high (sys_rst), sampled on the rising edge.
- Reset values:
  - valid_down=0, data_down=0, grant_id=0.
  - Internal last-grant pointer ptr=N-1, so requester 0 has top priority after reset.
- Reset dominates all other events in the same cycle. A beat in flight in the output register is discarded, with no downstream transfer.
- load_en = ~valid_down | ready_down (combinational). The output register can take a new beat when it is empty or draining this cycle.
- Arbitration (combinational, every cycle):
  - Scan order: ptr+1, ptr+2, ... wrapping modulo N, ending at ptr.
  - winner g = first index in that order with valid_up[g]=1. any_req = OR of valid_up.
- ready_up[i] = load_en & any_req & (i==g). All bits are 0 when there is no request.
- Upstream transfer for requester i: valid_up[i] & ready_up[i] on a rising edge.
- On an upstream transfer (at the clock edge):
  - data_down <= data_up[g]
  - grant_id <= g
  - valid_down <= 1
  - ptr <= g
- If load_en=1 and any_req=0:
  - valid_down <= 0; data_down and grant_id hold their values.
  - ptr unchanged.
- If load_en=0 (valid_down=1, ready_down=0): data_down, grant_id, valid_down and ptr all hold. Output stays stable until accepted.
- Simultaneous drain and fill (valid_down & ready_down & any_req):
  - The old beat leaves and the new winner's beat loads in the same edge.
  - No bubble, 1 beat/cycle sustained.
- Latency: 1 cycle from upstream transfer to valid_down.
- Fairness: with all N requesters continuously valid and ready_down=1, grants rotate 0,1,...,N-1,0,... A requester waits at most N-1 grants.
- Pointer updates only on an actual upstream transfer, never on a stalled arbitration. A requester that drops valid before being granted loses nothing.
- Upstream valid may change at any time. No grant lock is held across cycles, because the grant takes effect only in the transfer cycle.
- ready_up depends combinationally on ready_down and valid_up. There are no combinational paths from valid_up to valid_down or from data_up to data_down.
- Index arithmetic wraps modulo N. For N not a power of two, indices >= N never appear on grant_id.

Test Plan:
1. Reset, then valid_up=0000 for 5 cycles -> valid_down=0, ready_up=0000, grant_id=0, data_down=0 throughout.
2. Only requester 2 valid with data 3'd5, ready_down=1 -> ready_up=0100 the same cycle; next cycle valid_down=1, data_down=5, grant_id=2. Sustained valid gives one beat per cycle, all grant_id=2.
3. All four valid, data_up[i]=i+1, ready_down=1 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 and data_down 1,2,3,4,1,2,3,4, with no idle cycles.
4. Beat from requester 1 (data 3'd6) in output register, ready_down=0 for 3 cycles with requesters 0 and 3 valid -> ready_up=0000, data_down=6 and grant_id=1 held. When ready_down=1: same-edge load of requester 3 (after ptr=1, order 2,3,0) and valid_down remains 1.
5. Requester 0 valid alone, then requester 1 raises valid in the same cycle the output drains -> requester 1 wins next (ptr=0). Pointer is unchanged across stalled cycles.
6. sys_rst asserted while valid_down=1 and ready_down=0 -> next cycle valid_down=0 and ptr reset. After release, with all valid, the first grant_id is 0.

Source files
------------

// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
//
// N upstream requesters compete for a single depth-1 output register. The
// winner is chosen combinationally by scanning from the requester after the
// last granted one. Its beat is then captured together with its index.
// The last-grant pointer advances only on an actual upstream transfer.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   sys_rst     in   synchronous active-high reset
//   valid_up    in   [N]     per-requester valid
//   data_up     in   [N*DW]  requester i data at [i*DW +: DW]
//   ready_up    out  [N]     per-requester ready (one-hot or zero)
//   valid_down  out          output register holds a beat
//   data_down   out  [DW]    registered beat
//   grant_id    out  [IW]    index of requester that supplied data_down
//   ready_down  in           downstream accepts the beat
module rr_pipe_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 3,
  parameter int unsigned IW = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [N-1:0]    valid_up,
  input  logic [N*DW-1:0] data_up,
  output logic [N-1:0]    ready_up,
  output logic            valid_down,
  output logic [DW-1:0]   data_down,
  output logic [IW-1:0]   grant_id,
  input  logic            ready_down
);

  logic [IW-1:0] ptr_q;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] gid_q;

  logic          load_en;
  logic          any_req;
  logic [IW-1:0] winner;
  logic [DW-1:0] data_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = data_up[i*DW +: DW];
  end

  // Register can accept a beat when empty or draining this cycle.
  assign load_en = ~valid_q | ready_down;

  // Scan ptr+1 .. ptr (mod N); the first valid requester wins.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!any_req && valid_up[idx[IW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    ready_up = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ready_up[i] = load_en & any_req & (winner == i[IW-1:0]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ptr_q   <= IW'(N - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
    end else if (load_en) begin
      if (any_req) begin
        data_q  <= data_arr[winner];
        gid_q   <= winner;
        valid_q <= 1'b1;
        ptr_q   <= winner;
      end else begin
        // Empty or drained with nothing new: data and index hold.
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_down = valid_q;
  assign data_down  = data_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Self-checking bench for rr_pipe_arbiter (N=4, DW=3, IW=2).
// A reference model predicts each upstream transfer and queues the expected
// beat; beats are popped and compared as the DUT delivers them downstream.
module tb_rr_pipe_arbiter;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int IW = 2;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [N-1:0]    valid_up;
  logic [N*DW-1:0] data_up;
  logic [N-1:0]    ready_up;
  logic            valid_down;
  logic [DW-1:0]   data_down;
  logic [IW-1:0]   grant_id;
  logic            ready_down;

  rr_pipe_arbiter #(
    .N  (N),
    .DW (DW),
    .IW (IW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .valid_up   (valid_up),
    .data_up    (data_up),
    .ready_up   (ready_up),
    .valid_down (valid_down),
    .data_down  (data_down),
    .grant_id   (grant_id),
    .ready_down (ready_down)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [IW-1:0] gid;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    m_ptr = N - 1;
  logic  m_vd  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] up_data(input int i);
    return data_up[i*DW +: DW];
  endfunction

  // Inputs are already driven; sample at negedge, then advance the model and
  // return 1 time unit after the rising edge.
  task automatic cycle(input string tag);
    int            w;
    logic          le;
    logic [N-1:0]  exp_ru;
    beat_t         b;
    @(negedge sys_clk);
    le     = !m_vd || ready_down;
    w      = model_winner(valid_up);
    exp_ru = (le && w >= 0) ? N'(1 << w) : '0;
    check_eq({tag, ":ready_up"}, 32'(ready_up), 32'(exp_ru));
    check_eq({tag, ":valid_down"}, 32'(valid_down), 32'(m_vd));
    if (!sys_rst && m_vd && ready_down) begin
      if (sb_q.size() == 0) begin
        check_eq({tag, ":unexpected_beat"}, 32'(1), 32'(0));
      end else begin
        b = sb_q.pop_front();
        check_eq({tag, ":grant_id"}, 32'(grant_id), 32'(b.gid));
        check_eq({tag, ":data_down"}, 32'(data_down), 32'(b.data));
      end
    end
    if (sys_rst) begin
      m_vd  = 1'b0;
      m_ptr = N - 1;
      sb_q.delete();
    end else if (le) begin
      if (w >= 0) begin
        b.gid  = IW'(w);
        b.data = up_data(w);
        sb_q.push_back(b);
        m_vd  = 1'b1;
        m_ptr = w;
      end else begin
        m_vd = 1'b0;
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    data_up = {d3, d2, d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst    = 1'b1;
    valid_up   = '0;
    ready_down = 1'b0;
    set_data(3'd0, 3'd0, 3'd0, 3'd0);
    cycle("rst");
    cycle("rst");
    sys_rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      cycle("idle");
      check_eq("idle:data_down", 32'(data_down), 32'(0));
      check_eq("idle:grant_id", 32'(grant_id), 32'(0));
    end

    // 2: requester 2 alone, sustained
    ready_down = 1'b1;
    valid_up   = 4'b0100;
    set_data(3'd0, 3'd0, 3'd5, 3'd0);
    for (int i = 0; i < 4; i++) begin
      cycle("solo2");
      check_eq("solo2:grant_id", 32'(grant_id), 32'(2));
      check_eq("solo2:data_down", 32'(data_down), 32'(5));
    end
    valid_up = '0;
    cycle("solo2_drain");

    // 3: all valid after reset -> strict rotation from 0
    sys_rst = 1'b1;
    cycle("rst3");
    sys_rst = 1'b0;
    valid_up = 4'b1111;
    set_data(3'd1, 3'd2, 3'd3, 3'd4);
    for (int i = 0; i < 8; i++) begin
      cycle("rot");
      check_eq("rot:valid_down", 32'(valid_down), 32'(1));
      check_eq("rot:grant_seq", 32'(grant_id), 32'(i % 4));
      check_eq("rot:data_seq", 32'(data_down), 32'(i % 4 + 1));
    end

    // 4: stall with beat from requester 1 held
    valid_up = 4'b0010;
    set_data(3'd7, 3'd6, 3'd0, 3'd2);
    cycle("load1");
    valid_up   = 4'b1001;
    ready_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      check_eq("stall:data_down", 32'(data_down), 32'(6));
      check_eq("stall:grant_id", 32'(grant_id), 32'(1));
    end
    ready_down = 1'b1;
    cycle("unstall");
    check_eq("unstall:grant_id", 32'(grant_id), 32'(3));
    check_eq("unstall:valid_down", 32'(valid_down), 32'(1));

    // 5: requester 1 joins while output drains; stalls keep the pointer
    valid_up = 4'b0001;
    set_data(3'd3, 3'd4, 3'd0, 3'd0);
    cycle("req0");
    check_eq("req0:grant_id", 32'(grant_id), 32'(0));
    valid_up = 4'b0011;
    cycle("join1");
    check_eq("join1:grant_id", 32'(grant_id), 32'(1));
    ready_down = 1'b0;
    cycle("hold5");
    cycle("hold5");
    ready_down = 1'b1;
    cycle("resume5");
    check_eq("resume5:grant_id", 32'(grant_id), 32'(0));

    // 6: reset while a beat is stalled
    ready_down = 1'b0;
    valid_up   = '0;
    sys_rst    = 1'b1;
    cycle("rst6");
    check_eq("rst6:valid_down", 32'(valid_down), 32'(0));
    sys_rst    = 1'b0;
    ready_down = 1'b1;
    valid_up   = 4'b1111;
    cycle("post_rst");
    check_eq("post_rst:grant_id", 32'(grant_id), 32'(0));

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      valid_up   = N'($urandom_range(0, 15));
      ready_down = ($urandom_range(0, 3) != 0);
      data_up    = (N*DW)'($urandom);
      cycle("rand");
    end

    // Drain and confirm nothing left outstanding
    valid_up   = '0;
    ready_down = 1'b1;
    cycle("drain");
    cycle("drain");
    check_eq("drain:sb_empty", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
